obstacle_spawn_timer: RTL and testbench

Consumes the 4-bit pseudo-random nibble from the game's LFSR and turns it into randomized obstacle spawn intervals. Each interval is the 12-bit value {4'b0000, rand_bits, 4'b1111}, giving 15 to 255 frame ticks. After each interval expires the block raises a held spawn request toward the obstacle engine, then advances the LFSR for the next interval. It sits between the LFSR and the obstacle/sprite engine in the game-logic clock domain.

---
 rtl/obstacle_spawn_timer_pkg.sv | 20 ++
 rtl/spawn_interval_counter.sv | 41 ++++
 rtl/obstacle_spawn_timer.sv | 124 ++++++++++++
 tb/tb_obstacle_spawn_timer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawn_timer_pkg.sv
// Shared game-logic definitions for the obstacle spawn timer: state encoding
// and the spawn interval constants.
package obstacle_spawn_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_REQ   = 2'd2
    } spawn_state_e;

    localparam logic [3:0]  PAD_NIBBLE   = 4'hF;
    localparam int unsigned MIN_INTERVAL = 15;
    localparam int unsigned MAX_INTERVAL = 255;

    // Interval in ticks: {rand_nibble, pad}, i.e. 15..255.
    function automatic logic [7:0] interval_from_nibble(input logic [3:0] nib);
        return {nib, PAD_NIBBLE};
    endfunction

endpackage

// File: rtl/spawn_interval_counter.sv
// Loadable down-counter for spawn intervals, decremented on tick enable,
// with a flag marking the tick that brings the count to zero.
module spawn_interval_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_tick_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_tick_c = tick_i && !clear_i && !load_i && (count_q == WIDTH'(1));
    assign count_o     = count_q;

endmodule

// File: rtl/obstacle_spawn_timer.sv
// Turns LFSR nibbles into randomized obstacle spawn intervals and holds a
// spawn request toward the obstacle engine until it is acknowledged.
module obstacle_spawn_timer
    import obstacle_spawn_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic [3:0]       rand_bits,
    input  logic             spawn_ack,
    output logic             spawn_req,
    output logic             lfsr_step,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic [CNT_W-1:0] spawn_count
);

    spawn_state_e     state_q;
    spawn_state_e     state_d;

    logic             load_c;
    logic             clear_c;
    logic             cnt_tick_c;
    logic             ack_take_c;
    logic             last_tick_c;
    logic [WIDTH-1:0] load_val_c;

    logic             spawn_req_q;
    logic             lfsr_step_q;
    logic             busy_q;
    logic [CNT_W-1:0] spawn_count_q;

    assign load_val_c = WIDTH'(interval_from_nibble(rand_bits));

    spawn_interval_counter #(
        .WIDTH (WIDTH)
    ) u_interval (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear_c),
        .load_i      (load_c),
        .load_val_i  (load_val_c),
        .tick_i      (cnt_tick_c),
        .count_o     (remaining),
        .last_tick_c (last_tick_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping run wins over tick and ack in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (run) state_d = ST_COUNT;
            ST_COUNT: begin
                if (!run)             state_d = ST_IDLE;
                else if (last_tick_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!run)           state_d = ST_IDLE;
                else if (spawn_ack) state_d = ST_COUNT;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_c     = 1'b0;
        clear_c    = 1'b0;
        cnt_tick_c = 1'b0;
        ack_take_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) load_c  = 1'b1;
                else     clear_c = 1'b1;
            end
            ST_COUNT: begin
                if (!run) clear_c    = 1'b1;
                else      cnt_tick_c = tick;
            end
            ST_REQ: begin
                if (!run) begin
                    clear_c = 1'b1;
                end else if (spawn_ack) begin
                    load_c     = 1'b1;
                    ack_take_c = 1'b1;
                end
            end
            default: clear_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_req_q   <= 1'b0;
            lfsr_step_q   <= 1'b0;
            busy_q        <= 1'b0;
            spawn_count_q <= '0;
        end else begin
            spawn_req_q <= (state_d == ST_REQ);
            lfsr_step_q <= load_c;
            busy_q      <= (state_d != ST_IDLE);
            if (ack_take_c && (spawn_count_q != '1)) begin
                spawn_count_q <= spawn_count_q + CNT_W'(1);
            end
        end
    end

    assign spawn_req   = spawn_req_q;
    assign lfsr_step   = lfsr_step_q;
    assign busy        = busy_q;
    assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_obstacle_spawn_timer.sv
// Scoreboard bench for obstacle_spawn_timer: a tick-level behavioural model
// queues the expected outputs per cycle, a monitor pops and compares them.
module tb_obstacle_spawn_timer;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CNT_W = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             run = 1'b0;
    logic [3:0]       rand_bits = 4'h0;
    logic             spawn_ack = 1'b0;
    logic             spawn_req;
    logic             lfsr_step;
    logic             busy;
    logic [WIDTH-1:0] remaining;
    logic [CNT_W-1:0] spawn_count;

    typedef struct {
        logic             req;
        logic             step;
        logic             busy;
        logic [WIDTH-1:0] rem;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: game active, request pending, ticks left in interval, accepted spawns.
    bit m_active  = 1'b0;
    bit m_waiting = 1'b0;
    bit m_step    = 1'b0;
    int m_left    = 0;
    int m_count   = 0;

    obstacle_spawn_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .run         (run),
        .rand_bits   (rand_bits),
        .spawn_ack   (spawn_ack),
        .spawn_req   (spawn_req),
        .lfsr_step   (lfsr_step),
        .busy        (busy),
        .remaining   (remaining),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the edge.
    task automatic step(input bit rs, input bit rn, input bit tk, input bit ak, input logic [3:0] rb);
        exp_t e;
        @(negedge clk);
        reset     = rs;
        run       = rn;
        tick      = tk;
        spawn_ack = ak;
        rand_bits = rb;
        m_step    = 1'b0;
        if (rs) begin
            m_active  = 1'b0;
            m_waiting = 1'b0;
            m_left    = 0;
            m_count   = 0;
        end else if (!rn) begin
            m_active  = 1'b0;
            m_waiting = 1'b0;
            m_left    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_left   = int'(rb) * 16 + 15;
            m_step   = 1'b1;
        end else if (m_waiting) begin
            if (ak) begin
                if (m_count < CNT_MAX) m_count++;
                m_left    = int'(rb) * 16 + 15;
                m_waiting = 1'b0;
                m_step    = 1'b1;
            end
        end else if (tk) begin
            m_left--;
            if (m_left == 0) m_waiting = 1'b1;
        end
        e.req  = m_waiting;
        e.step = m_step;
        e.busy = m_active;
        e.rem  = WIDTH'(m_left);
        e.cnt  = CNT_W'(m_count);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("spawn_req",   32'(spawn_req),   32'(mon_e.req));
            check("lfsr_step",   32'(lfsr_step),   32'(mon_e.step));
            check("busy",        32'(busy),        32'(mon_e.busy));
            check("remaining",   32'(remaining),   32'(mon_e.rem));
            check("spawn_count", 32'(spawn_count), 32'(mon_e.cnt));
        end
    end

    initial begin
        repeat (2) step(1, 0, 0, 0, 4'h0);

        // Minimum interval, then ack on the cycle after the request rises.
        step(0, 1, 0, 0, 4'h0);
        repeat (15) step(0, 1, 1, 0, 4'($urandom));
        step(0, 1, 0, 1, 4'h5);

        // Maximum interval, long unacknowledged request, ack reloads 63.
        step(0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'hF);
        repeat (254) step(0, 1, 1, 0, 4'($urandom));
        step(0, 1, 1, 0, 4'h0);
        repeat (40) step(0, 1, 1, 0, 4'($urandom));
        step(0, 1, 0, 1, 4'h3);

        // Pause mid-count at remaining=100, then resume with a fresh load.
        step(0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h6);
        repeat (11) step(0, 1, 1, 0, 4'h0);
        step(0, 0, 1, 1, 4'h2);
        step(0, 0, 0, 0, 4'h2);
        step(0, 1, 0, 0, 4'h9);

        // run drop coinciding with ack in REQ: not counted, no LFSR step.
        step(0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        repeat (15) step(0, 1, 1, 0, 4'h0);
        step(0, 0, 0, 1, 4'h0);

        // Reset while a request is held.
        step(0, 1, 0, 0, 4'h0);
        repeat (15) step(0, 1, 1, 0, 4'h0);
        step(1, 1, 1, 1, 4'h0);
        step(0, 0, 0, 0, 4'h0);

        // 300 back-to-back minimum intervals with ack held: count saturates.
        step(0, 1, 0, 0, 4'h0);
        repeat (300 * 16) step(0, 1, 1, 1, 4'h0);

        // Randomized traffic with rare pauses and resets.
        repeat (4000) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
